rr_arb_2to1: RTL and testbench

Two-source, packet-aware round-robin arbiter that merges two valid/ready byte streams onto one output stream. It generates the registered select that steers the 2:1 data mux, and it owns the output holding register. It sits directly upstream of the mux-based datapath: it decides which input the mux passes and when, and it locks the grant for the duration of a packet.

---
 rtl/rr_arb_2to1_pkg.sv | 23 ++
 rtl/rr_arb_2to1_if.sv | 49 ++++
 rtl/mux_2to1.sv | 12 +
 rtl/rr_arb_2to1_dp.sv | 33 +++
 rtl/rr_arb_2to1.sv | 162 ++++++++++++++++
 tb/tb_rr_arb_2to1.sv | 286 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rr_arb_2to1_pkg.sv
// Shared types and constants for the rr_arb_2to1 round-robin arbiter.
package rr_arb_2to1_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    // Mux select encoding; last_grant uses the same encoding.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Width of the per-source packet counters.
    localparam int STAT_W = 16;

    // Saturating increment for the packet counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb_2to1_if.sv
// Bundle of the two input streams, the merged output stream and the mux
// select for rr_arb_2to1.
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high. A source holds valid, data and last stable until that edge; ready
// may change at any time and never depends on the same-side valid.
interface rr_arb_2to1_if #(
    parameter int DW = 8
);
    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_last;
    logic          a_ready;

    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_last;
    logic          b_ready;

    logic          y_valid;
    logic [DW-1:0] y_data;
    logic          y_last;
    logic          y_ready;

    logic          sel;

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output a_valid, a_data, a_last,
        input  a_ready,
        output b_valid, b_data, b_last,
        input  b_ready,
        input  y_valid, y_data, y_last,
        output y_ready,
        input  sel
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, a_last,
        output a_ready,
        input  b_valid, b_data, b_last,
        output b_ready,
        output y_valid, y_data, y_last,
        input  y_ready,
        output sel
    );

endinterface

// File: rtl/mux_2to1.sv
// Single-bit 2:1 mux: s=0 passes a, s=1 passes b.
module mux_2to1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    // Plain select.
    assign y = s ? b : a;

endmodule

// File: rtl/rr_arb_2to1_dp.sv
// Data path selection for rr_arb_2to1: one mux_2to1 per data bit plus one
// for the last flag, all steered by the registered select.
module rr_arb_2to1_dp #(
    parameter int DW = 8
) (
    input  logic          sel,
    input  logic [DW-1:0] a_data,
    input  logic          a_last,
    input  logic [DW-1:0] b_data,
    input  logic          b_last,
    output logic [DW-1:0] mux_data,
    output logic          mux_last
);

    // Bit-sliced data mux.
    for (genvar i = 0; i < DW; i++) begin : g_bit
        mux_2to1 u_mux (
            .a (a_data[i]),
            .b (b_data[i]),
            .s (sel),
            .y (mux_data[i])
        );
    end

    // Last-flag mux.
    mux_2to1 u_mux_last (
        .a (a_last),
        .b (b_last),
        .s (sel),
        .y (mux_last)
    );

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-source packet-aware round-robin arbiter with output holding register.
// Optional feature macro: ARB_STATS_EN adds saturating per-source packet
// counters cnt_a / cnt_b.
module rr_arb_2to1
    import rr_arb_2to1_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_arb_2to1_if.slave       bus,
    output arb_state_e         dbg_state
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]  cnt_a,
    output logic [STAT_W-1:0]  cnt_b
`endif
);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_grant_q, last_grant_d;
    logic          in_pkt_q, in_pkt_d;
    logic          y_valid_q;
    logic [DW-1:0] y_data_q;
    logic          y_last_q;
    logic          out_free;
    logic          a_ready_c, b_ready_c;
    logic          xfer;
    logic [DW-1:0] mux_data;
    logic          mux_last;

    rr_arb_2to1_dp #(.DW(DW)) u_dp (
        .sel      (sel_q),
        .a_data   (bus.a_data),
        .a_last   (bus.a_last),
        .b_data   (bus.b_data),
        .b_last   (bus.b_last),
        .mux_data (mux_data),
        .mux_last (mux_last)
    );

    // The holding register can take a beat when empty or being drained.
    assign out_free = ~y_valid_q | bus.y_ready;

    // Next-state, grant and transfer decode. mux_last is the granted
    // source's last flag because sel_q always tracks the grant state.
    // Between packets (in_pkt_q low) a granted source that drops valid
    // releases the grant so the other source cannot be starved.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        in_pkt_d     = in_pkt_q;
        a_ready_c    = 1'b0;
        b_ready_c    = 1'b0;
        xfer         = 1'b0;
        case (state_q)
            IDLE: begin
                in_pkt_d = 1'b0;
                if (bus.a_valid && bus.b_valid)
                    state_d = (last_grant_q == SEL_B) ? GRANT_A : GRANT_B;
                else if (bus.a_valid)
                    state_d = GRANT_A;
                else if (bus.b_valid)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                a_ready_c = out_free;
                xfer      = bus.a_valid & out_free;
                if (xfer) begin
                    if (mux_last) begin
                        in_pkt_d = 1'b0;
                        state_d  = bus.b_valid ? GRANT_B :
                                   (bus.a_valid ? GRANT_A : IDLE);
                    end else begin
                        in_pkt_d = 1'b1;
                    end
                end else if (!in_pkt_q && !bus.a_valid) begin
                    state_d = IDLE;
                end
            end
            GRANT_B: begin
                b_ready_c = out_free;
                xfer      = bus.b_valid & out_free;
                if (xfer) begin
                    if (mux_last) begin
                        in_pkt_d = 1'b0;
                        state_d  = bus.a_valid ? GRANT_A :
                                   (bus.b_valid ? GRANT_B : IDLE);
                    end else begin
                        in_pkt_d = 1'b1;
                    end
                end else if (!in_pkt_q && !bus.b_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                in_pkt_d = 1'b0;
            end
        endcase
        if (state_d == GRANT_A)
            last_grant_d = SEL_A;
        else if (state_d == GRANT_B)
            last_grant_d = SEL_B;
        sel_d = (state_d == GRANT_B) ? SEL_B : SEL_A;
    end

    // FSM, select and fairness registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= SEL_A;
            last_grant_q <= SEL_B;
            in_pkt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            in_pkt_q     <= in_pkt_d;
        end
    end

    // Output holding register: load on transfer, otherwise drain on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_last_q  <= 1'b0;
        end else if (xfer) begin
            y_valid_q <= 1'b1;
            y_data_q  <= mux_data;
            y_last_q  <= mux_last;
        end else if (bus.y_ready) begin
            y_valid_q <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    // Per-source packet counters, bumped on each accepted last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (xfer && mux_last) begin
            if (sel_q == SEL_A)
                cnt_a <= sat_inc(cnt_a);
            else
                cnt_b <= sat_inc(cnt_b);
        end
    end
`endif

    assign bus.a_ready = a_ready_c;
    assign bus.b_ready = b_ready_c;
    assign bus.y_valid = y_valid_q;
    assign bus.y_data  = y_data_q;
    assign bus.y_last  = y_last_q;
    assign bus.sel     = sel_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Directed testbench for rr_arb_2to1 (build with or without ARB_STATS_EN).
module tb_rr_arb_2to1;
    import rr_arb_2to1_pkg::*;

    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_arb_2to1_if #(.DW(DW)) bus ();
    arb_state_e dbg_state;
`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] cnt_a, cnt_b;
`endif

    rr_arb_2to1 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef ARB_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every beat leaving the output port must match the next expected beat.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_beat", 32'(exp_q.size()), 1);
            else
                check("sb_data", bus.y_data, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.a_valid = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
        bus.b_valid = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
        bus.y_ready = 1'b1;
    endtask

    task automatic set_random();
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_data  = 8'($urandom_range(0, 255));
        bus.a_last  = 1'($urandom_range(0, 1));
        bus.b_valid = 1'($urandom_range(0, 1));
        bus.b_data  = 8'($urandom_range(0, 255));
        bus.b_last  = 1'($urandom_range(0, 1));
        bus.y_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_vals();
        check("rst_state",   32'(dbg_state), 32'(IDLE));
        check("rst_sel",     bus.sel, 0);
        check("rst_a_ready", bus.a_ready, 0);
        check("rst_b_ready", bus.b_ready, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_y_data",  bus.y_data, 0);
        check("rst_y_last",  bus.y_last, 0);
`ifdef ARB_STATS_EN
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_random();
        tick();
        check_reset_vals();
        set_random();
        tick();
        check_reset_vals();
        rst = 1'b0;
        set_idle();
    endtask

    // Send one packet from src (0=A, 1=B); waits for each beat's acceptance.
    task automatic send_pkt(input logic src, input int nbeats, input logic [DW-1:0] base);
        logic acc;
        int   guard;
        for (int j = 0; j < nbeats; j++) begin
            exp_q.push_back(base + DW'(j));
            if (src) begin
                bus.b_valid = 1'b1; bus.b_data = base + DW'(j); bus.b_last = (j == nbeats - 1);
            end else begin
                bus.a_valid = 1'b1; bus.a_data = base + DW'(j); bus.a_last = (j == nbeats - 1);
            end
            guard = 0;
            do begin
                acc = src ? (bus.b_valid & bus.b_ready) : (bus.a_valid & bus.a_ready);
                tick();
                guard++;
            end while (!acc && guard < 40);
            check("pkt_beat_accepted", acc, 1);
        end
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        bus.b_valid = 1'b0; bus.b_last = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();

        // Reset with random inputs.
        do_reset();
        tick();
        check("idle_state", 32'(dbg_state), 32'(IDLE));

        // Single source A: 0x11, 0x22, 0x33(last).
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        bus.a_valid = 1'b1; bus.a_data = 8'h11; bus.a_last = 1'b0;
        tick();
        check("ss_state",   32'(dbg_state), 32'(GRANT_A));
        check("ss_sel",     bus.sel, 0);
        check("ss_a_ready", bus.a_ready, 1);
        check("ss_y_valid0", bus.y_valid, 0);
        tick();
        check("ss_y_data0", bus.y_data, 8'h11);
        check("ss_y_last0", bus.y_last, 0);
        check("ss_a_ready1", bus.a_ready, 1);
        bus.a_data = 8'h22;
        tick();
        check("ss_y_data1", bus.y_data, 8'h22);
        check("ss_y_last1", bus.y_last, 0);
        bus.a_data = 8'h33; bus.a_last = 1'b1;
        tick();
        check("ss_y_data2", bus.y_data, 8'h33);
        check("ss_y_last2", bus.y_last, 1);
        check("ss_sel2",    bus.sel, 0);
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        tick();
        check("ss_drained", bus.y_valid, 0);
        check("ss_back_idle", 32'(dbg_state), 32'(IDLE));

        // Fairness: both sources offer 1-beat packets back to back.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            exp_q.push_back(8'hB0 + 8'(i));
        end
        bus.a_valid = 1'b1; bus.a_data = 8'hA0; bus.a_last = 1'b1;
        bus.b_valid = 1'b1; bus.b_data = 8'hB0; bus.b_last = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) begin
                check("fair_first_grant", 32'(dbg_state), 32'(GRANT_A));
                check("fair_sel0", bus.sel, 0);
            end else begin
                check("fair_y_valid", bus.y_valid, 1);
                check("fair_y_data", bus.y_data,
                      (k % 2 == 1) ? 32'(8'hA0 + 8'((k - 1) / 2)) : 32'(8'hB0 + 8'((k - 2) / 2)));
                check("fair_sel", bus.sel, 32'(k % 2));
            end
            if (k == 8) begin
                bus.a_valid = 1'b0; bus.b_valid = 1'b0;
                bus.a_last  = 1'b0; bus.b_last  = 1'b0;
            end else begin
                bus.a_data = 8'hA0 + 8'((k + 1) / 2);
                bus.b_data = 8'hB0 + 8'(k / 2);
            end
        end
        tick();
        check("fair_drained", bus.y_valid, 0);

        // Packet lock: B mid 4-beat packet when A arrives.
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        exp_q.push_back(8'h55);
        bus.b_valid = 1'b1; bus.b_data = 8'hC0; bus.b_last = 1'b0;
        tick();
        check("lock_sel_b", bus.sel, 1);
        check("lock_b_ready", bus.b_ready, 1);
        tick();
        check("lock_y_c0", bus.y_data, 8'hC0);
        bus.a_valid = 1'b1; bus.a_data = 8'h55; bus.a_last = 1'b1;
        bus.b_data = 8'hC1;
        #1;
        check("lock_a_ready0", bus.a_ready, 0);
        tick();
        check("lock_a_ready1", bus.a_ready, 0);
        check("lock_sel_held", bus.sel, 1);
        check("lock_y_c1", bus.y_data, 8'hC1);
        bus.b_data = 8'hC2;
        tick();
        check("lock_a_ready2", bus.a_ready, 0);
        check("lock_y_c2", bus.y_data, 8'hC2);
        bus.b_data = 8'hC3; bus.b_last = 1'b1;
        tick();
        check("lock_y_c3", bus.y_data, 8'hC3);
        check("lock_y_last", bus.y_last, 1);
        check("lock_handover", 32'(dbg_state), 32'(GRANT_A));
        check("lock_sel_a", bus.sel, 0);
        check("lock_a_ready_now", bus.a_ready, 1);
        bus.b_valid = 1'b0; bus.b_last = 1'b0;
        tick();
        check("lock_y_a", bus.y_data, 8'h55);
        check("lock_y_a_valid", bus.y_valid, 1);
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        tick();
        check("lock_drained", bus.y_valid, 0);

        // Backpressure: y_ready low for 3 cycles while y_valid is high.
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h61 + 8'(i));
        bus.a_valid = 1'b1; bus.a_data = 8'h61; bus.a_last = 1'b0;
        tick();
        tick();
        check("bp_y_61", bus.y_data, 8'h61);
        bus.y_ready = 1'b0; bus.a_data = 8'h62;
        #1;
        check("bp_a_ready_low", bus.a_ready, 0);
        for (int h = 0; h < 3; h++) begin
            tick();
            check("bp_hold_valid", bus.y_valid, 1);
            check("bp_hold_data", bus.y_data, 8'h61);
            check("bp_hold_ready", bus.a_ready, 0);
        end
        bus.y_ready = 1'b1;
        #1;
        check("bp_a_ready_back", bus.a_ready, 1);
        tick();
        check("bp_y_62", bus.y_data, 8'h62);
        bus.a_data = 8'h63;
        tick();
        check("bp_y_63", bus.y_data, 8'h63);
        bus.a_data = 8'h64; bus.a_last = 1'b1;
        tick();
        check("bp_y_64", bus.y_data, 8'h64);
        check("bp_y_last", bus.y_last, 1);
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        tick();
        check("bp_drained", bus.y_valid, 0);
        check("bp_sb_empty", 32'(exp_q.size()), 0);

        // Packet counting: 5 A packets (2 beats) and 3 B packets (1 beat).
        do_reset();
        send_pkt(1'b0, 2, 8'h10);
        send_pkt(1'b1, 1, 8'h20);
        send_pkt(1'b0, 2, 8'h30);
        send_pkt(1'b1, 1, 8'h40);
        send_pkt(1'b0, 2, 8'h50);
        send_pkt(1'b1, 1, 8'h60);
        send_pkt(1'b0, 2, 8'h70);
        send_pkt(1'b0, 2, 8'h80);
        repeat (3) tick();
        check("pkt_sb_empty", 32'(exp_q.size()), 0);
`ifdef ARB_STATS_EN
        check("cnt_a", cnt_a, 5);
        check("cnt_b", cnt_b, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
